cmp_sel_shift_pipe: RTL and testbench

CMP_SEL_SHIFT_PIPE -- requirements
Module: cmp_sel_shift_pipe

---
 rtl/cmp_sel_shift_pkg.sv | 29 ++
 rtl/cmp_sel_shift_pipe_stage.sv | 30 +++
 rtl/cmp_sel_shift_pipe.sv | 103 ++++++++++
 tb/tb_cmp_sel_shift_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sel_shift_pkg.sv
// Shared constants and the output narrowing helper for cmp_sel_shift_pipe.
package cmp_sel_shift_pkg;

  localparam int unsigned WIDTH_MIN     = 8;
  localparam int unsigned WIDTH_MAX     = 128;
  localparam int unsigned OUT_WIDTH_MIN = 1;
  localparam int unsigned NARROW_W      = 128;

  // Narrow a sign-extended value to ow bits: either keep the low bits
  // (caller truncates) or clamp to the signed ow-bit range.
  function automatic logic [NARROW_W-1:0] sat_narrow(
    input logic signed [NARROW_W-1:0] v,
    input int unsigned                ow,
    input bit                         sat
  );
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    sat_narrow = v;
    if (sat && ow >= 1 && ow < NARROW_W) begin
      hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (v > hi)
        sat_narrow = hi;
      else if (v < lo)
        sat_narrow = lo;
    end
  endfunction

endpackage

// File: rtl/cmp_sel_shift_pipe_stage.sv
// Single valid/ready register slice with asynchronous active-low reset.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Slot is free when empty or when its contents leave this cycle.
  assign in_ready = !out_valid || out_ready;

  // Load on input transfer; empty when drained with nothing arriving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= in_data;
    end
  end

endmodule

// File: rtl/cmp_sel_shift_pipe.sv
// Two-stage compare/select/conditional-shift pipeline with valid/ready flow control.
module cmp_sel_shift_pipe
  import cmp_sel_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHAMT     = 1,
  parameter bit          ASR       = 1'b1,
  parameter bit          SAT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic signed [WIDTH-1:0]     c,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic        [OUT_WIDTH-1:0] x,
  output logic        [OUT_WIDTH-1:0] z,
  output logic                        out_valid,
  input  logic                        out_ready
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("cmp_sel_shift_pipe: WIDTH out of range");
  end
  if (OUT_WIDTH < OUT_WIDTH_MIN || OUT_WIDTH > WIDTH) begin : g_bad_out_width
    $error("cmp_sel_shift_pipe: OUT_WIDTH out of range");
  end
  if (SHAMT > WIDTH - 1) begin : g_bad_shamt
    $error("cmp_sel_shift_pipe: SHAMT out of range");
  end

  localparam int unsigned S1W = 2 * WIDTH + 2;
  localparam int unsigned S2W = 2 * OUT_WIDTH;

  logic signed [WIDTH-1:0] d, e, f;
  logic        [WIDTH-1:0] g, h;
  logic                    dlte, deqe;

  logic [S1W-1:0]   s1_d, s1_q;
  logic             s1_valid, s2_ready;
  logic [WIDTH-1:0] g_q, h_q;
  logic             dlte_q, deqe_q;

  int unsigned          xamt, zamt;
  logic [WIDTH-1:0]     xr, zr;
  logic [OUT_WIDTH-1:0] xn, zn;
  logic [S2W-1:0]       s2_d, s2_q;

  // Stage 1 combinational: sums, signed compare and the two selects.
  always_comb begin
    d    = a + b;
    e    = a + c;
    f    = a - b;
    dlte = d < e;
    deqe = d == e;
    g    = dlte ? e : d;
    h    = deqe ? f : g;
  end

  assign s1_d = {g, h, dlte, deqe};
  assign {g_q, h_q, dlte_q, deqe_q} = s1_q;

  pipe_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  // Stage 2 combinational: conditional shifts, then narrow to OUT_WIDTH.
  always_comb begin
    xamt = dlte_q ? SHAMT : 32'd0;
    zamt = deqe_q ? SHAMT : 32'd0;
    xr   = h_q << xamt;
    if (ASR)
      zr = $signed(g_q) >>> zamt;
    else
      zr = g_q >> zamt;
    xn = OUT_WIDTH'(sat_narrow(128'($signed(xr)), OUT_WIDTH, SAT));
    zn = OUT_WIDTH'(sat_narrow(128'($signed(zr)), OUT_WIDTH, SAT));
  end

  assign s2_d = {xn, zn};
  assign {x, z} = s2_q;

  pipe_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

endmodule

// File: tb/tb_cmp_sel_shift_pipe.sv
// Scoreboard bench for cmp_sel_shift_pipe: default instance plus an ASR=0/SAT=1 instance.
module tb_cmp_sel_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [63:0] a, b, c;
  logic               in_valid, out_ready;
  logic               in_ready, out_valid, irs, ovs;
  logic [31:0]        x, z, xs, zs;

  cmp_sel_shift_pipe #(.WIDTH(64), .OUT_WIDTH(32), .SHAMT(1), .ASR(1'b1), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .z(z), .out_valid(out_valid), .out_ready(out_ready)
  );

  cmp_sel_shift_pipe #(.WIDTH(64), .OUT_WIDTH(32), .SHAMT(1), .ASR(1'b0), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid), .in_ready(irs),
    .x(xs), .z(zs), .out_valid(ovs), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] x, z, xs, zs;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_out   = 0;
  bit   mon_en  = 1'b0;

  function automatic logic [31:0] narrow32(input longint v, input bit sat);
    if (sat && v > 64'sd2147483647) return 32'h7fffffff;
    if (sat && v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic void model(input longint ai, bi, ci, input bit asr, sat,
                                output logic [31:0] xo, zo);
    longint d, e, f, g, h, xr, zr;
    bit lt, eq;
    d  = ai + bi;
    e  = ai + ci;
    f  = ai - bi;
    lt = d < e;
    eq = d == e;
    g  = lt ? e : d;
    h  = eq ? f : g;
    xr = lt ? (h <<< 1) : h;
    if (!eq)      zr = g;
    else if (asr) zr = g >>> 1;
    else          zr = longint'({1'b0, g[63:1]});
    xo = narrow32(xr, sat);
    zo = narrow32(zr, sat);
  endfunction

  function automatic exp_t make_exp(input longint ai, bi, ci);
    exp_t r;
    model(ai, bi, ci, 1'b1, 1'b0, r.x, r.z);
    model(ai, bi, ci, 1'b0, 1'b1, r.xs, r.zs);
    return r;
  endfunction

  task automatic monitor();
    logic [31:0] px, pz, pxs, pzs;
    bit pstall;
    exp_t e;
    pstall = 1'b0;
    px = '0; pz = '0; pxs = '0; pzs = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst) begin
        q.delete();
        pstall = 1'b0;
      end else begin
        n_total++;
        if (in_ready !== !(q.size() == 2 && !out_ready))
          $display("FAIL in_ready: got %b, expected %b (in flight %0d, out_ready %b)",
                   in_ready, !(q.size() == 2 && !out_ready), q.size(), out_ready);
        else n_pass++;
        n_total++;
        if ({irs, ovs} !== {in_ready, out_valid})
          $display("FAIL sat_handshake: got %b%b, expected %b%b", irs, ovs, in_ready, out_valid);
        else n_pass++;
        if (pstall) begin
          n_total++;
          if ({out_valid, x, z, xs, zs} !== {1'b1, px, pz, pxs, pzs})
            $display("FAIL stall_hold: got v=%b %h %h %h %h, expected v=1 %h %h %h %h",
                     out_valid, x, z, xs, zs, px, pz, pxs, pzs);
          else n_pass++;
        end
        if (out_valid && out_ready) begin
          n_total++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_output: got x=%h z=%h, expected no output", x, z);
          end else begin
            e = q.pop_front();
            n_out++;
            if ({x, z, xs, zs} !== {e.x, e.z, e.xs, e.zs})
              $display("FAIL scoreboard: got %h %h %h %h, expected %h %h %h %h",
                       x, z, xs, zs, e.x, e.z, e.xs, e.zs);
            else n_pass++;
          end
        end
        if (in_valid && in_ready)
          q.push_back(make_exp(a, b, c));
        pstall = out_valid && !out_ready;
        px = x; pz = z; pxs = xs; pzs = zs;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    n_total++;
    if (q.size() != 0) $display("FAIL drain: got %0d pending, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    a = 5; b = 3; c = 1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({in_ready, out_valid, x, z, xs, zs} !== {1'b1, 1'b0, 128'd0})
      $display("FAIL reset_state: got rdy=%b v=%b %h %h %h %h, expected rdy=1 v=0 zeros",
               in_ready, out_valid, x, z, xs, zs);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_no_accept: got %b, expected 0", out_valid);
    else n_pass++;
    rst = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL first_latency1: got %b, expected 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, x, z} !== {1'b1, 32'd8, 32'd8})
      $display("FAIL first_transfer: got v=%b x=%0d z=%0d, expected v=1 x=8 z=8", out_valid, x, z);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    a = 5; b = 3; c = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL basic_latency1: got %b, expected 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, x, z} !== {1'b1, 32'd8, 32'd8})
      $display("FAIL basic: got v=%b x=%0d z=%0d, expected v=1 x=8 z=8", out_valid, x, z);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    a = 5; b = 2; c = 4; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 5; b = 3; c = 3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, x, z} !== {1'b1, 32'd18, 32'd9})
      $display("FAIL b2b_first: got v=%b x=%0d z=%0d, expected v=1 x=18 z=9", out_valid, x, z);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, x, z} !== {1'b1, 32'd2, 32'd4})
      $display("FAIL b2b_second: got v=%b x=%0d z=%0d, expected v=1 x=2 z=4", out_valid, x, z);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_corners();
    @(posedge clk); #1;
    a = -9; b = 0; c = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 64'sd1 <<< 40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if ({x, z, xs, zs} !== {32'hfffffff7, 32'hfffffffb, 32'hfffffff7, 32'h7fffffff})
      $display("FAIL neg9: got %h %h %h %h, expected fffffff7 fffffffb fffffff7 7fffffff",
               x, z, xs, zs);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({x, z, xs, zs} !== {32'h0, 32'h0, 32'h7fffffff, 32'h7fffffff})
      $display("FAIL big40: got %h %h %h %h, expected 0 0 7fffffff 7fffffff", x, z, xs, zs);
    else n_pass++;
    wait_drain();
  endtask

  task automatic pick_vec();
    case ($urandom_range(0, 3))
      0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; end
      1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = b; end
      2: begin
        a = longint'($urandom_range(0, 200)) - 100;
        b = longint'($urandom_range(0, 200)) - 100;
        c = longint'($urandom_range(0, 200)) - 100;
      end
      default: begin
        a = longint'($signed($urandom)) <<< 9;
        b = longint'($signed($urandom)) <<< 8;
        c = longint'($signed($urandom)) <<< 8;
      end
    endcase
  endtask

  task automatic test_stream();
    int sent, n0;
    bit acc;
    sent = 0;
    n0 = n_out;
    @(posedge clk); #1;
    pick_vec();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 500 && sent < 20; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        sent++;
        if (sent < 20) pick_vec();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_total++;
    if (sent != 20) $display("FAIL stream_send: got %0d sent, expected 20", sent);
    else n_pass++;
    wait_drain();
    n_total++;
    if (n_out - n0 != 20) $display("FAIL stream_count: got %0d outputs, expected 20", n_out - n0);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 5; b = 3; c = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = -9; b = 0; c = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, in_ready} !== 2'b10)
      $display("FAIL full_stall: got v=%b rdy=%b, expected v=1 rdy=0", out_valid, in_ready);
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready, x, z} !== {1'b0, 1'b1, 64'd0})
      $display("FAIL async_reset: got v=%b rdy=%b x=%h z=%h, expected v=0 rdy=1 x=0 z=0",
               out_valid, in_ready, x, z);
    else n_pass++;
    @(posedge clk); #1;
    a = 5; b = 2; c = 4; in_valid = 1'b1; out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, x, z} !== {1'b1, 32'd18, 32'd9})
      $display("FAIL post_reset_first: got v=%b x=%0d z=%0d, expected v=1 x=18 z=9",
               out_valid, x, z);
    else n_pass++;
    wait_drain();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 0; b = 0; c = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_corners();
    test_stream();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
